activ_deser_sr: RTL and testbench

ACTIV_DESER_SR -- requirements
Module: activ_deser_sr

---
 rtl/activ_deser_sr_pkg.sv | 13 +
 rtl/activ_deser_sr_if.sv | 29 ++
 rtl/activ_deser_sr.sv | 97 +++++++++
 tb/tb_activ_deser_sr.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/activ_deser_sr_pkg.sv
// Shared types and constants for the serial-to-parallel activation deserializer.
package activ_deser_sr_pkg;

  // Default parallel word width.
  localparam int PA_DEFAULT = 8;

  // IDLE: no bits of the current word received yet; SHIFT: partial word held.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/activ_deser_sr_if.sv
// Serial input, abort and ready/valid output bundle of the deserializer.
interface activ_deser_sr_if
  import activ_deser_sr_pkg::*;
#(
  parameter int Pa = PA_DEFAULT
);

  logic          s_en;
  logic          in_ser;
  logic          clr;
  logic          out_ready;
  logic [Pa-1:0] out_par;
  logic          out_valid;
  logic          busy;
  logic          ovf;

  // Producer of serial bits and consumer of parallel words.
  modport master (
    output s_en, in_ser, clr, out_ready,
    input  out_par, out_valid, busy, ovf
  );

  // The deserializer itself.
  modport slave (
    input  s_en, in_ser, clr, out_ready,
    output out_par, out_valid, busy, ovf
  );

endinterface

// File: rtl/activ_deser_sr.sv
// Serial-to-parallel deserializer: collects Pa bits LSB first, then offers the
// word on a single-entry ready/valid output; a word completing while the
// output is still occupied is dropped and flagged in a sticky overflow bit.
module activ_deser_sr
  import activ_deser_sr_pkg::*;
#(
  parameter int Pa = PA_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  activ_deser_sr_if.slave bus
);

  localparam int CW = $clog2(Pa);
  localparam logic [CW-1:0] CNT_LAST = CW'(Pa - 1);

  state_t        state_q;
  state_t        state_d;
  logic [Pa-1:0] sh;
  logic [CW-1:0] cnt;
  logic [Pa-1:0] word;
  logic          sample;
  logic          last;
  logic          xfer;
  logic          accept;

  assign sample = bus.s_en & ~bus.clr;
  assign last   = sample && (cnt == CNT_LAST);
  assign xfer   = bus.out_valid & bus.out_ready;
  // Output register can take the completed word if empty or emptying now.
  assign accept = last && (!bus.out_valid || bus.out_ready);
  assign bus.busy = (state_q == SHIFT);

  // Shift register contents after this edge's sample: new bit enters at the MSB.
  always_comb begin
    word         = sh >> 1;
    word[Pa-1]   = bus.in_ser;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clr aborts, the last bit of a word returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else if (sample) begin
      state_d = last ? IDLE : SHIFT;
    end
  end

  // Shift register and bit counter; clr discards the partial word and the same-edge bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (bus.clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (sample) begin
      sh  <= word;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

  // Output word register and valid flag; clr leaves these untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_par   <= '0;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_par   <= word;
      bus.out_valid <= 1'b1;
    end else if (xfer) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Sticky overflow: set when a completed word finds the output blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ovf <= 1'b0;
    end else if (bus.clr) begin
      bus.ovf <= 1'b0;
    end else if (last && bus.out_valid && !bus.out_ready) begin
      bus.ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_activ_deser_sr.sv
// Self-checking bench for activ_deser_sr with Pa=8 and a word scoreboard.
module tb_activ_deser_sr;

  localparam int PA = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [PA-1:0] sb[$];
  logic [PA-1:0] exp_w;

  activ_deser_sr_if #(.Pa(PA)) bus ();

  activ_deser_sr #(.Pa(PA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One sampled bit; returns 1 time unit after the edge.
  task automatic send_bit(input logic b);
    bus.s_en   = 1'b1;
    bus.in_ser = b;
    @(posedge clk);
    #1;
    bus.s_en   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // Whole word with s_en held high; the expected word goes into the scoreboard.
  task automatic send_word(input logic [PA-1:0] w, input bit expect_out);
    if (expect_out) sb.push_back(w);
    for (int i = 0; i < PA; i++) send_bit(w[i]);
  endtask

  task automatic test_reset();
    bus.s_en = 0; bus.in_ser = 0; bus.clr = 0; bus.out_ready = 0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_par !== 8'h00) begin failures++; $display("FAIL reset_par got %h want 00", bus.out_par); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_continuous();
    bus.out_ready = 1'b1;
    sb.push_back(8'hA5);
    for (int i = 0; i < PA; i++) begin
      send_bit(exp_bit(8'hA5, i));
      if (i == 0) begin
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL cont_busy got %b want 1", bus.busy); end
      end
    end
    exp_w = sb.pop_front();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL cont_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL cont_par got %h want %h", bus.out_par, exp_w); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cont_busy_end got %b want 0", bus.busy); end
    idle_cycle();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL cont_valid_drop got %b want 0", bus.out_valid); end
  endtask

  function automatic logic exp_bit(input logic [PA-1:0] w, input int i);
    return w[i];
  endfunction

  task automatic test_gapped();
    bus.out_ready = 1'b1;
    sb.push_back(8'h3C);
    for (int i = 0; i < PA; i++) begin
      send_bit(exp_bit(8'h3C, i));
      if (i < PA - 1) begin
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL gap_busy bit%0d got %b want 1", i, bus.busy); end
        idle_cycle();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gap_early_valid bit%0d got %b want 0", i, bus.out_valid); end
      end
    end
    exp_w = sb.pop_front();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL gap_par got %h want %h", bus.out_par, exp_w); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL gap_busy_end got %b want 0", bus.busy); end
    idle_cycle();
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    exp_w = sb.pop_front();
    checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL ovf_par got %h want %h", bus.out_par, exp_w); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got %b want 1", bus.ovf); end
    bus.out_ready = 1'b1;
    idle_cycle();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ovf_consume got %b want 0", bus.out_valid); end
    checks++; if (bus.ovf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b want 1", bus.ovf); end
    bus.clr = 1'b1;
    idle_cycle();
    bus.clr = 1'b0;
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got %b want 0", bus.ovf); end
  endtask

  task automatic test_clr_partial();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL clr_busy_pre got %b want 1", bus.busy); end
    // clr wins over a simultaneous strobe
    bus.clr = 1'b1; bus.s_en = 1'b1; bus.in_ser = 1'b1;
    idle_cycle();
    bus.clr = 1'b0; bus.s_en = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL clr_busy_post got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL clr_valid got %b want 0", bus.out_valid); end
    send_word(8'hF0, 1'b1);
    exp_w = sb.pop_front();
    checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL clr_par got %h want %h", bus.out_par, exp_w); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL clr_word_valid got %b want 1", bus.out_valid); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    send_word(8'h7E, 1'b1);
    exp_w = sb.pop_front();
    checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL b2b_first got %h want %h", bus.out_par, exp_w); end
    sb.push_back(8'h81);
    for (int i = 0; i < PA; i++) begin
      if (i == PA - 1) bus.out_ready = 1'b1;
      send_bit(exp_bit(8'h81, i));
    end
    bus.out_ready = 1'b0;
    exp_w = sb.pop_front();
    checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL b2b_second got %h want %h", bus.out_par, exp_w); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL b2b_ovf got %b want 0", bus.ovf); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_par !== 8'h00) begin failures++; $display("FAIL arst_par got %h want 00", bus.out_par); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got %b want 0", bus.busy); end
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL arst_ovf got %b want 0", bus.ovf); end
    #1;
    rst_n = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b1;
    send_word(8'h5A, 1'b1);
    exp_w = sb.pop_front();
    checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL arst_word got %h want %h", bus.out_par, exp_w); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_word_valid got %b want 1", bus.out_valid); end
    idle_cycle();
  endtask

  task automatic test_random_words();
    logic [PA-1:0] w;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      w = PA'($urandom);
      send_word(w, 1'b1);
      exp_w = sb.pop_front();
      checks++; if (bus.out_par !== exp_w) begin failures++; $display("FAIL rand_word%0d got %h want %h", n, bus.out_par, exp_w); end
      if (n[0]) idle_cycle();
    end
    idle_cycle();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_empty got %0d want 0", sb.size()); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_continuous();
    test_gapped();
    test_overflow();
    test_clr_partial();
    test_back_to_back();
    test_async_reset();
    test_random_words();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
